wb_result_checker: RTL and testbench

- Synthesizable self-checking monitor for the LEGv8 core's register write-back port.
- Holds a loadable table of expected (register, value) results and checks observed write-backs against it, in order.
- Reports pass, fail or timeout as status outputs.
- Generalises the per-program hard-coded bench checks (factorial result, sorted array) into one parametrised block that bench tops or FPGA debug wrappers instantiate next to the core.

---
 rtl/wb_result_checker_if.sv | 19 +
 rtl/wb_result_checker.sv | 134 +++++++++++++
 tb/tb_wb_result_checker.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_result_checker_if.sv
// wb_result_checker_if: write-back observation and expected-table load bus
//   master drives, slave (the checker) samples:
//   wb_en/wb_reg/wb_data      core register write-back port
//   exp_we/exp_addr/exp_reg/exp_data  expected-table write port
interface wb_result_checker_if #(
    parameter int WORD   = 64,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 16
);
    logic                     wb_en;
    logic [REG_AW-1:0]        wb_reg;
    logic [WORD-1:0]          wb_data;
    logic                     exp_we;
    logic [$clog2(DEPTH)-1:0] exp_addr;
    logic [REG_AW-1:0]        exp_reg;
    logic [WORD-1:0]          exp_data;
    modport master (output wb_en, wb_reg, wb_data, exp_we, exp_addr, exp_reg, exp_data);
    modport slave  (input  wb_en, wb_reg, wb_data, exp_we, exp_addr, exp_reg, exp_data);
endinterface

// File: rtl/wb_result_checker.sv
// wb_result_checker: checks observed register write-backs against a loaded table of expected results
//   clk, rst        clock, synchronous active-high reset
//   start_i         one-cycle pulse starting a check run
//   num_exp_i       entries to check, sampled on start_i (clamped to DEPTH)
//   bus             write-back and expected-table bus (slave)
//   busy_o          run in progress
//   done_o          run finished (pass, fail or timeout)
//   pass_o/fail_o/timed_out_o  final status
//   match_cnt_o     entries matched so far
//   fail_idx_o      entry index at a strict mismatch
//   fail_got_o      write-back value captured at a strict mismatch
module wb_result_checker #(
    parameter int WORD    = 64,
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 16,
    parameter int STRICT  = 0,
    parameter int TIMEOUT = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic [$clog2(DEPTH+1)-1:0] num_exp_i,
    wb_result_checker_if.slave         bus,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic                       fail_o,
    output logic                       timed_out_o,
    output logic [$clog2(DEPTH+1)-1:0] match_cnt_o,
    output logic [$clog2(DEPTH)-1:0]   fail_idx_o,
    output logic [WORD-1:0]            fail_got_o
);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TMO} state_t;

    state_t            state_q, state_d;
    logic [NW-1:0]     match_cnt_q, match_cnt_d;
    logic [NW-1:0]     n_q, n_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [AW-1:0]     fail_idx_q, fail_idx_d;
    logic [WORD-1:0]   fail_got_q, fail_got_d;
    logic [REG_AW-1:0] tbl_reg_q  [DEPTH];
    logic [WORD-1:0]   tbl_data_q [DEPTH];

    logic          run;
    logic          qual;
    logic          hit;
    logic          strict_miss;
    logic          complete;
    logic          tmo;
    logic [AW-1:0] idx;
    logic [NW-1:0] n_new;

    assign run   = state_q == RUN;
    // match_cnt stays below N <= DEPTH while running, so the truncation is lossless
    assign idx   = AW'(match_cnt_q);
    assign n_new = (num_exp_i > NW'(DEPTH)) ? NW'(DEPTH) : num_exp_i;
    // XZR (register 31) writes never count as results
    assign qual        = run && bus.wb_en && bus.wb_reg != REG_AW'(31);
    assign hit         = qual && tbl_reg_q[idx] == bus.wb_reg && tbl_data_q[idx] == bus.wb_data;
    assign strict_miss = (STRICT != 0) && qual && !hit;
    assign complete    = hit && match_cnt_q + NW'(1) == n_q;
    assign tmo         = cyc_q == CW'(TIMEOUT - 1);

    // Table is deliberately outside reset so a run can be replayed after rst
    always_ff @(posedge clk) begin
        if (bus.exp_we && !run) begin
            tbl_reg_q[bus.exp_addr]  <= bus.exp_reg;
            tbl_data_q[bus.exp_addr] <= bus.exp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            match_cnt_q <= '0;
            n_q         <= '0;
            cyc_q       <= '0;
            fail_idx_q  <= '0;
            fail_got_q  <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            n_q         <= n_d;
            cyc_q       <= cyc_d;
            fail_idx_q  <= fail_idx_d;
            fail_got_q  <= fail_got_d;
        end
    end

    // Priority in RUN: completing match, then strict mismatch, then timeout
    always_comb begin
        state_d = state_q;
        if (run)
            state_d = complete ? PASS : strict_miss ? FAIL : tmo ? TMO : RUN;
        else if (start_i)
            state_d = (n_new == '0) ? PASS : RUN;
    end

    // Counters and capture registers hold in terminal states
    always_comb begin
        match_cnt_d = match_cnt_q;
        n_d         = n_q;
        cyc_d       = cyc_q;
        fail_idx_d  = fail_idx_q;
        fail_got_d  = fail_got_q;
        if (run) begin
            cyc_d       = cyc_q + CW'(1);
            match_cnt_d = hit ? match_cnt_q + NW'(1) : match_cnt_q;
            fail_idx_d  = strict_miss ? idx : fail_idx_q;
            fail_got_d  = strict_miss ? bus.wb_data : fail_got_q;
        end else if (start_i) begin
            match_cnt_d = '0;
            n_d         = n_new;
            cyc_d       = '0;
            fail_idx_d  = '0;
            fail_got_d  = '0;
        end
    end

    always_comb begin
        busy_o      = state_q == RUN;
        pass_o      = state_q == PASS;
        fail_o      = state_q == FAIL;
        timed_out_o = state_q == TMO;
        done_o      = pass_o || fail_o || timed_out_o;
        match_cnt_o = match_cnt_q;
        fail_idx_o  = fail_idx_q;
        fail_got_o  = fail_got_q;
    end
endmodule

// File: tb/tb_wb_result_checker.sv
// tb_wb_result_checker: lax (STRICT=0) and strict (STRICT=1) checkers side by side against a rule-level model
module tb_wb_result_checker;
    localparam int TMO_CYC = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  num_exp;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [63:0] wb_data;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic [4:0]  exp_reg;
    logic [63:0] exp_data;

    logic [1:0]  busy, done, pass, fail, tout;
    logic [4:0]  mcnt [2];
    logic [3:0]  fidx [2];
    logic [63:0] fgot [2];

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : u
        wb_result_checker_if #(.WORD(64), .REG_AW(5), .DEPTH(16)) bus ();
        assign bus.wb_en    = wb_en;
        assign bus.wb_reg   = wb_reg;
        assign bus.wb_data  = wb_data;
        assign bus.exp_we   = exp_we;
        assign bus.exp_addr = exp_addr;
        assign bus.exp_reg  = exp_reg;
        assign bus.exp_data = exp_data;
        wb_result_checker #(.WORD(64), .REG_AW(5), .DEPTH(16), .STRICT(g), .TIMEOUT(TMO_CYC)) dut (
            .clk        (clk),
            .rst        (rst),
            .start_i    (start),
            .num_exp_i  (num_exp),
            .bus        (bus.slave),
            .busy_o     (busy[g]),
            .done_o     (done[g]),
            .pass_o     (pass[g]),
            .fail_o     (fail[g]),
            .timed_out_o(tout[g]),
            .match_cnt_o(mcnt[g]),
            .fail_idx_o (fidx[g]),
            .fail_got_o (fgot[g])
        );
    end

    // Model status: 0 idle, 1 running, 2 pass, 3 fail, 4 timeout
    int          ms [2];
    int          mc [2];
    int          my [2];
    int          mn [2];
    int          mfi [2];
    logic [63:0] mfg [2];
    logic [4:0]  tr [2][16];
    logic [63:0] td [2][16];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ms[i] = 0; mc[i] = 0; my[i] = 0; mn[i] = 0; mfi[i] = 0; mfg[i] = '0;
            end else if (ms[i] == 1) begin
                my[i]++;
                if (wb_en && wb_reg != 5'd31) begin
                    if (tr[i][mc[i]] == wb_reg && td[i][mc[i]] == wb_data) begin
                        mc[i]++;
                        if (mc[i] == mn[i]) ms[i] = 2;
                    end else if (i == 1) begin
                        ms[i] = 3; mfi[i] = mc[i]; mfg[i] = wb_data;
                    end
                end
                if (ms[i] == 1 && my[i] == TMO_CYC) ms[i] = 4;
            end else begin
                if (exp_we) begin
                    tr[i][exp_addr] = exp_reg;
                    td[i][exp_addr] = exp_data;
                end
                if (start) begin
                    mn[i] = (num_exp > 16) ? 16 : int'(num_exp);
                    mc[i] = 0; my[i] = 0; mfi[i] = 0; mfg[i] = '0;
                    ms[i] = (mn[i] == 0) ? 2 : 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                logic [77:0] act, exq;
                act = {busy[i], done[i], pass[i], fail[i], tout[i], mcnt[i], fidx[i], fgot[i]};
                exq = {ms[i] == 1, ms[i] >= 2, ms[i] == 2, ms[i] == 3, ms[i] == 4,
                       5'(mc[i]), 4'(mfi[i]), mfg[i]};
                checks++;
                if (act !== exq) begin
                    errors++;
                    $display("FAIL model[%0d] t=%0t got %h expected %h", i, $time, act, exq);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] r, input logic [63:0] d);
        wb_en = 1'b1; wb_reg = r; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    task automatic load(input int a, input logic [4:0] r, input logic [63:0] d);
        exp_we = 1'b1; exp_addr = 4'(a); exp_reg = r; exp_data = d;
        step();
        exp_we = 1'b0;
    endtask

    task automatic go(input int n);
        start = 1'b1; num_exp = 5'(n);
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_exp = '0; wb_en = 1'b0; wb_reg = '0; wb_data = '0;
        exp_we = 1'b0; exp_addr = '0; exp_reg = '0; exp_data = '0;
        step(); step();
        rst = 1'b0;
        armed = 1'b1;
        step();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_mcnt", 64'(mcnt[0]), 64'd0);

        load(0, 5'd9, 64'd720);
        go(1);
        wb(5'd9, 64'd1);
        chk("fact_strict_fail", 64'(fail[1]), 64'd1);
        chk("fact_strict_got", fgot[1], 64'd1);
        wb(5'd9, 64'd2); wb(5'd9, 64'd6); wb(5'd9, 64'd24); wb(5'd9, 64'd120);
        chk("fact_not_yet", 64'(pass[0]), 64'd0);
        wb(5'd9, 64'd720);
        chk("fact_pass", 64'(pass[0]), 64'd1);
        chk("fact_mcnt", 64'(mcnt[0]), 64'd1);
        chk("fact_nofail", 64'(fail[0]), 64'd0);

        load(0, 5'd9, 64'h1); load(1, 5'd9, 64'h2); load(2, 5'd9, 64'h27);
        load(3, 5'd9, 64'h45); load(4, 5'd9, 64'h99);
        go(5);
        wb(5'd9, 64'h1); wb(5'd31, 64'h7); wb(5'd9, 64'h2); wb(5'd31, 64'h0);
        wb(5'd9, 64'h27); wb(5'd9, 64'h45); wb(5'd31, 64'h99);
        chk("sort_busy", 64'(busy[1]), 64'd1);
        wb(5'd9, 64'h99);
        chk("sort_pass", 64'(pass[1]), 64'd1);
        chk("sort_mcnt", 64'(mcnt[1]), 64'd5);

        go(5);
        wb(5'd9, 64'h1); wb(5'd9, 64'h2); wb(5'd9, 64'h28);
        chk("mis_fail", 64'(fail[1]), 64'd1);
        chk("mis_idx", 64'(fidx[1]), 64'd2);
        chk("mis_got", fgot[1], 64'h28);
        chk("mis_mcnt", 64'(mcnt[1]), 64'd2);
        chk("mis_lax_busy", 64'(busy[0]), 64'd1);
        wb(5'd9, 64'h27);
        chk("mis_hold_fail", 64'(fail[1]), 64'd1);
        chk("mis_hold_mcnt", 64'(mcnt[1]), 64'd2);
        chk("mis_lax_mcnt", 64'(mcnt[0]), 64'd3);
        wb(5'd9, 64'h45); wb(5'd9, 64'h99);
        chk("mis_lax_pass", 64'(pass[0]), 64'd1);

        go(3);
        repeat (TMO_CYC - 1) step();
        chk("tmo_not_yet", 64'(tout), 64'd0);
        step();
        chk("tmo_hit", 64'(tout), 64'd3);

        go(1);
        repeat (TMO_CYC - 1) step();
        wb(5'd9, 64'h1);
        chk("edge_pass", 64'(pass), 64'd3);
        chk("edge_no_tmo", 64'(tout), 64'd0);

        go(1);
        repeat (TMO_CYC - 1) step();
        wb(5'd9, 64'h5);
        chk("edge_strict_fail", 64'(fail[1]), 64'd1);
        chk("edge_lax_tmo", 64'(tout[0]), 64'd1);

        go(0);
        chk("zero_pass", 64'(pass), 64'd3);
        chk("zero_busy", 64'(busy), 64'd0);

        for (int i = 0; i < 16; i++) load(i, 5'(i + 1), 64'(100 + i));
        go(19);
        for (int i = 0; i < 15; i++) begin
            wb(5'(i + 1), 64'(100 + i));
            if (i == 5) go(1);
        end
        chk("clamp_busy", 64'(busy[1]), 64'd1);
        chk("clamp_mcnt15", 64'(mcnt[1]), 64'd15);
        wb(5'd16, 64'd115);
        chk("clamp_pass", 64'(pass[1]), 64'd1);
        chk("clamp_mcnt16", 64'(mcnt[1]), 64'd16);

        go(16);
        wb(5'd1, 64'd100); wb(5'd2, 64'd101);
        chk("rst_pre_mcnt", 64'(mcnt[1]), 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_mcnt", 64'(mcnt[1]), 64'd0);
        go(16);
        load(2, 5'd9, 64'hdead);
        for (int i = 0; i < 16; i++) wb(5'(i + 1), 64'(100 + i));
        chk("replay_pass", 64'(pass), 64'd3);
        chk("replay_mcnt", 64'(mcnt[0]), 64'd16);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
